// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types and decode helpers for the two-master system bus.
//   state_t     : sequencer states (IDLE -> ACCESS -> DONE -> IDLE)
//   region_t    : decoded slave region of an address
//   DIODES_BASE : top address nibble that selects the diodes block
//   WAIT_W      : width of the per-region wait-state counter
//   region_of() : maps the top address nibble to a region
// -----------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_DIODES,
    REG_NONE
  } region_t;

  localparam logic [3:0] DIODES_BASE = 4'b1001;
  localparam int         WAIT_W      = 8;

  // RAM owns the whole lower half of the map; the diodes own one 4K page in
  // the upper half; everything else is unmapped.
  function automatic region_t region_of(input logic [3:0] addr_hi);
    region_t r;
    if (!addr_hi[3]) begin
      r = REG_RAM;
    end else if (addr_hi == DIODES_BASE) begin
      r = REG_DIODES;
    end else begin
      r = REG_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_decoder.sv
// -----------------------------------------------------------------------------
// bus_decoder
// Combinational address decoder for the system bus. Kept separate so future
// slaves can reuse the same region map and wait-state table.
// Ports:
//   addr_hi   in  4       top nibble of the bus address (all the map looks at)
//   region    out region  decoded region
//   cs_ram    out 1       address falls in RAM
//   cs_diodes out 1       address falls in the diodes page
//   wait_cnt  out WAIT_W  extra ACCESS cycles for the region (0 if unmapped)
// -----------------------------------------------------------------------------
import bus_pkg::*;

module bus_decoder #(
  parameter int RAM_WAIT = 0,
  parameter int IO_WAIT  = 1
) (
  input  logic [3:0]        addr_hi,
  output region_t           region,
  output logic              cs_ram,
  output logic              cs_diodes,
  output logic [WAIT_W-1:0] wait_cnt
);

  always_comb begin
    region    = region_of(addr_hi);
    cs_ram    = (region == REG_RAM);
    cs_diodes = (region == REG_DIODES);
    case (region)
      REG_RAM:    wait_cnt = WAIT_W'(RAM_WAIT);
      REG_DIODES: wait_cnt = WAIT_W'(IO_WAIT);
      default:    wait_cnt = '0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-master arbiter and bus sequencer for the shared system bus. Master 0 is
// the CPU, master 1 a DMA/secondary requester. One master is picked per
// transfer, its request is latched, the address is decoded into chip selects,
// per-region wait states are inserted and read data is returned with a
// one-cycle ready pulse.
// Ports:
//   clk, reset (async, active low)
//   mX_req/mX_r/mX_w/mX_addr/mX_wdata  in   master X request, direction, payload
//   mX_gnt                             out  master X owns the bus (ACCESS, DONE)
//   mX_ready                           out  one-cycle completion pulse
//   mX_rdata                           out  read data, valid with mX_ready
//   bus_addr/bus_wdata                 out  latched address / write data
//   bus_rdata                          in   slave read data
//   bus_r/bus_w                        out  slave strobes (ACCESS, mapped only)
//   cs_ram/cs_diodes                   out  slave selects (ACCESS, mapped only)
//   err                                out  with ready on unmapped or r&w access
// -----------------------------------------------------------------------------
import bus_pkg::*;

module bus_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RAM_WAIT   = 0,
  parameter int IO_WAIT    = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_r,
  input  logic                  m0_w,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_ready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_r,
  input  logic                  m1_w,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_ready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_r,
  output logic                  bus_w,
  output logic                  cs_ram,
  output logic                  cs_diodes,
  output logic                  err
);

  localparam int                BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  // Sequencer state
  state_t state_q, state_d;

  // Arbitration
  logic                  m0_elig, m1_elig, take;
  logic                  cand;          // 0 = m0, 1 = m1
  logic                  cand_r, cand_w;
  logic [ADDR_WIDTH-1:0] cand_addr;
  logic [DATA_WIDTH-1:0] cand_wdata;
  logic                  last_q;        // master granted most recently
  logic [BURST_W-1:0]    burst_q;       // consecutive grants to last_q (saturating)

  // Latched transfer
  logic                  owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  illegal_q;
  region_t               region_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
  logic [DATA_WIDTH-1:0] access_rdata;
  logic                  mapped;

  // Decoder
  logic [ADDR_WIDTH-1:0] dec_addr;
  region_t               dec_region;
  logic                  dec_cs_ram, dec_cs_diodes;
  logic [WAIT_W-1:0]     dec_wait;

  // ---------------------------------------------------------------------------
  // Arbitration: pick a candidate among the eligible masters
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults or full if/else); a missed branch would infer a latch.
  always_comb begin
    m0_elig = m0_req & (m0_r | m0_w);
    m1_elig = m1_req & (m1_r | m1_w);
    if (m0_elig && m1_elig) begin
      // The holder keeps the bus until it has used MAX_BURST grants in a row.
      // Straight out of reset burst_q is 0 and last_q is 0, so m0 is favoured.
      cand = (burst_q < BURST_MAX) ? last_q : ~last_q;
    end else begin
      cand = m1_elig;
    end
    take       = (state_q == IDLE) && (m0_elig || m1_elig);
    cand_r     = cand ? m1_r     : m0_r;
    cand_w     = cand ? m1_w     : m0_w;
    cand_addr  = cand ? m1_addr  : m0_addr;
    cand_wdata = cand ? m1_wdata : m0_wdata;
  end

  // In IDLE the decoder looks at the candidate so its wait count can be
  // latched; afterwards it decodes the latched address to drive the selects.
  assign dec_addr = (state_q == IDLE) ? cand_addr : addr_q;

  bus_decoder #(
    .RAM_WAIT (RAM_WAIT),
    .IO_WAIT  (IO_WAIT)
  ) u_decoder (
    .addr_hi   (dec_addr[ADDR_WIDTH-1 -: 4]),
    .region    (dec_region),
    .cs_ram    (dec_cs_ram),
    .cs_diodes (dec_cs_diodes),
    .wait_cnt  (dec_wait)
  );

  assign mapped       = (region_q != REG_NONE);
  assign access_rdata = mapped ? bus_rdata : '1;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = ACCESS;
      ACCESS:  if (wait_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    err       = 1'b0;
    bus_r     = 1'b0;
    bus_w     = 1'b0;
    cs_ram    = 1'b0;
    cs_diodes = 1'b0;
    case (state_q)
      ACCESS: begin
        m0_gnt    = ~owner_q;
        m1_gnt    = owner_q;
        // The decoder returns no select for unmapped addresses, and the
        // strobes follow the same rule so nothing on the bus moves.
        cs_ram    = dec_cs_ram;
        cs_diodes = dec_cs_diodes;
        bus_r     = mapped & ~write_q;
        bus_w     = mapped & write_q;
      end
      DONE: begin
        m0_gnt   = ~owner_q;
        m1_gnt   = owner_q;
        m0_ready = ~owner_q;
        m1_ready = owner_q;
        err      = illegal_q | ~mapped;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transfer datapath: latch on a win, count waits, capture read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= 1'b0;
      last_q     <= 1'b0;
      burst_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      illegal_q  <= 1'b0;
      region_q   <= REG_NONE;
      wait_q     <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            owner_q   <= cand;
            addr_q    <= cand_addr;
            wdata_q   <= cand_wdata;
            write_q   <= cand_w;              // r&w together is serviced as a write
            illegal_q <= cand_r & cand_w;
            region_q  <= dec_region;
            wait_q    <= dec_wait;
            last_q    <= cand;
            if ((cand == last_q) && (burst_q != '0)) begin
              if (burst_q < BURST_MAX) burst_q <= burst_q + BURST_W'(1);
            end else begin
              burst_q <= BURST_W'(1);
            end
          end
        end
        ACCESS: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - WAIT_W'(1);
          end else if (owner_q) begin
            m1_rdata_q <= access_rdata;
          end else begin
            m0_rdata_q <= access_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter. A transfer-level reference model (grant
// history queue, region table by address range, per-master read-data copies)
// predicts each transfer; the observed transfer is summarised cycle by cycle
// and compared against the prediction.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int RAM_WAIT  = 0;
  localparam int IO_WAIT   = 1;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req, m0_r, m0_w, m1_req, m1_r, m1_w;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_ready, m1_gnt, m1_ready;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_r, bus_w, cs_ram, cs_diodes, err;

  always #5 clk = ~clk;

  bus_arbiter #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .RAM_WAIT   (RAM_WAIT),
    .IO_WAIT    (IO_WAIT),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_r      (m0_r),
    .m0_w      (m0_w),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_ready  (m0_ready),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_r      (m1_r),
    .m1_w      (m1_w),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_ready  (m1_ready),
    .m1_rdata  (m1_rdata),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_r     (bus_r),
    .bus_w     (bus_w),
    .cs_ram    (cs_ram),
    .cs_diodes (cs_diodes),
    .err       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Summary of one transfer as seen on the pins.
  typedef struct packed {
    logic        timeout;
    logic        winner;
    logic [7:0]  lat;        // negedges from request set-up to ready
    logic [3:0]  n_cs_ram;
    logic [3:0]  n_cs_io;
    logic [3:0]  n_r;
    logic [3:0]  n_w;
    logic [3:0]  n_gnt0;
    logic [3:0]  n_gnt1;
    logic [15:0] acc_addr;
    logic [15:0] acc_wdata;
    logic        stable;
    logic        err;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
  } xfer_t;

  // Reference model state
  logic        hist[$];
  logic [15:0] mdl_rdata[2];

  function automatic logic pick(input logic e0, input logic e1);
    int   streak;
    logic last;
    if (e0 && !e1) return 1'b0;
    if (e1 && !e0) return 1'b1;
    if (hist.size() == 0) return 1'b0;
    last   = hist[hist.size()-1];
    streak = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != last) break;
      streak++;
    end
    return (streak < MAX_BURST) ? last : !last;
  endfunction

  function automatic xfer_t expect_for(input logic win, input logic [15:0] addr,
                                       input logic [15:0] wdata, input logic r,
                                       input logic w, input logic [15:0] rd);
    xfer_t e;
    logic  ram, io, mapped;
    int    wt;
    ram    = (addr < 16'h8000);
    io     = (addr >= 16'h9000) && (addr < 16'hA000);
    mapped = ram || io;
    wt     = ram ? RAM_WAIT : (io ? IO_WAIT : 0);
    e           = '0;
    e.winner    = win;
    e.lat       = 8'(2 + wt);
    e.n_cs_ram  = ram ? 4'(1 + wt) : 4'd0;
    e.n_cs_io   = io  ? 4'(1 + wt) : 4'd0;
    e.n_r       = (mapped && !w) ? 4'(1 + wt) : 4'd0;
    e.n_w       = (mapped &&  w) ? 4'(1 + wt) : 4'd0;
    e.n_gnt0    = win ? 4'd0 : 4'(2 + wt);
    e.n_gnt1    = win ? 4'(2 + wt) : 4'd0;
    e.acc_addr  = addr;
    e.acc_wdata = wdata;
    e.stable    = 1'b1;
    e.err       = !mapped || (r && w);
    e.rdata0    = mdl_rdata[0];
    e.rdata1    = mdl_rdata[1];
    if (win) e.rdata1 = mapped ? rd : 16'hFFFF;
    else     e.rdata0 = mapped ? rd : 16'hFFFF;
    return e;
  endfunction

  // Watches the pins from the cycle after request set-up until a ready pulse.
  task automatic observe(output xfer_t o);
    logic first;
    first     = 1'b1;
    o         = '0;
    o.stable  = 1'b1;
    o.timeout = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      o.n_cs_ram = o.n_cs_ram + 4'(cs_ram);
      o.n_cs_io  = o.n_cs_io  + 4'(cs_diodes);
      o.n_r      = o.n_r      + 4'(bus_r);
      o.n_w      = o.n_w      + 4'(bus_w);
      o.n_gnt0   = o.n_gnt0   + 4'(m0_gnt);
      o.n_gnt1   = o.n_gnt1   + 4'(m1_gnt);
      if (m0_ready || m1_ready) begin
        o.timeout = 1'b0;
        o.lat     = 8'(k);
        o.winner  = m1_ready;
        o.err     = err;
        o.rdata0  = m0_rdata;
        o.rdata1  = m1_rdata;
        break;
      end
      if (m0_gnt || m1_gnt) begin
        if (first) begin
          o.acc_addr  = bus_addr;
          o.acc_wdata = bus_wdata;
          first       = 1'b0;
        end else if (bus_addr !== o.acc_addr || bus_wdata !== o.acc_wdata) begin
          o.stable = 1'b0;
        end
      end
    end
  endtask

  // Runs one transfer from an IDLE-cycle negedge with the master inputs as
  // currently driven; ends on the following IDLE-cycle negedge.
  task automatic do_round(output xfer_t got, output xfer_t exp, output logic idle_ok);
    logic e0, e1, w;
    e0  = m0_req && (m0_r || m0_w);
    e1  = m1_req && (m1_r || m1_w);
    w   = pick(e0, e1);
    exp = w ? expect_for(1'b1, m1_addr, m1_wdata, m1_r, m1_w, bus_rdata)
            : expect_for(1'b0, m0_addr, m0_wdata, m0_r, m0_w, bus_rdata);
    observe(got);
    if (got.timeout) begin
      m0_req = 1'b0;
      m1_req = 1'b0;
    end else if (got.winner) begin
      m1_req = 1'b0;
    end else begin
      m0_req = 1'b0;
    end
    hist.push_back(w);
    mdl_rdata[w] = w ? exp.rdata1 : exp.rdata0;
    @(negedge clk);
    idle_ok = !(m0_ready || m1_ready || m0_gnt || m1_gnt);
  endtask

  task automatic set_m0(input logic req, input logic r, input logic w,
                        input logic [15:0] addr, input logic [15:0] wdata);
    m0_req = req; m0_r = r; m0_w = w; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic r, input logic w,
                        input logic [15:0] addr, input logic [15:0] wdata);
    m1_req = req; m1_r = r; m1_w = w; m1_addr = addr; m1_wdata = wdata;
  endtask

  function automatic logic [15:0] rand_addr(input int kind);
    logic [15:0] a;
    case (kind)
      0:       a = 16'($urandom_range(0, 16'h7FFF));
      1:       a = 16'h9000 | 16'($urandom_range(0, 16'h0FFF));
      default: a = ($urandom_range(0, 1) == 0) ? (16'h8000 | 16'($urandom_range(0, 16'h0FFF)))
                                               : 16'($urandom_range(16'hA000, 16'hFFFF));
    endcase
    return a;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    set_m0(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({m0_gnt, m1_gnt, m0_ready, m1_ready, err, bus_r, bus_w, cs_ram, cs_diodes} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {m0_gnt, m1_gnt, m0_ready, m1_ready, err, bus_r, bus_w, cs_ram, cs_diodes});
    end
    n_cmp++;
    if ({bus_addr, bus_wdata, m0_rdata, m1_rdata} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {bus_addr, bus_wdata, m0_rdata, m1_rdata});
    end
    m0_req = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m0_gnt, m1_gnt, m0_ready, m1_ready, bus_r, bus_w} !== 6'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got %b want 000000",
               {m0_gnt, m1_gnt, m0_ready, m1_ready, bus_r, bus_w});
    end
  endtask

  task automatic test_ram_read();
    xfer_t got, exp;
    logic  idle_ok;
    bus_rdata = 16'h1234;
    set_m0(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    do_round(got, exp, idle_ok);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL ram_read: got %h want %h", got, exp); end
    n_cmp++;
    if (got.lat !== 8'd2 || got.rdata0 !== 16'h1234 || got.err !== 1'b0) begin
      n_bad++;
      $display("FAIL ram_read_fixed: got lat=%0d rdata=%h err=%b want lat=2 rdata=1234 err=0",
               got.lat, got.rdata0, got.err);
    end
    n_cmp++;
    if (!idle_ok) begin n_bad++; $display("FAIL ram_read_ready_width: got extra cycle want one"); end
  endtask

  task automatic test_io_write();
    xfer_t got, exp;
    logic  idle_ok;
    bus_rdata = 16'h0F0F;
    set_m1(1'b1, 1'b0, 1'b1, 16'h9000, 16'hBEEF);
    do_round(got, exp, idle_ok);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL io_write: got %h want %h", got, exp); end
    n_cmp++;
    if (got.lat !== 8'd3 || got.n_w !== 4'd2 || got.n_cs_io !== 4'd2 || got.acc_wdata !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL io_write_fixed: got lat=%0d bus_w=%0d cs=%0d wdata=%h want 3 2 2 beef",
               got.lat, got.n_w, got.n_cs_io, got.acc_wdata);
    end
    n_cmp++;
    if (!idle_ok) begin n_bad++; $display("FAIL io_write_ready_width: got extra cycle want one"); end
  endtask

  task automatic test_no_direction();
    logic seen;
    seen = 1'b0;
    set_m0(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
    repeat (4) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt || bus_r || bus_w) seen = 1'b1;
    end
    m0_req = 1'b0;
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL no_direction: got grant want none"); end
  endtask

  task automatic test_unmapped();
    xfer_t got, exp;
    logic  idle_ok;
    bus_rdata = 16'h5555;
    set_m0(1'b1, 1'b1, 1'b0, 16'hA000, 16'h0000);
    do_round(got, exp, idle_ok);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL unmapped: got %h want %h", got, exp); end
    n_cmp++;
    if (got.err !== 1'b1 || got.rdata0 !== 16'hFFFF || got.n_r !== 4'd0 || got.n_cs_ram !== 4'd0) begin
      n_bad++;
      $display("FAIL unmapped_fixed: got err=%b rdata=%h r=%0d cs=%0d want 1 ffff 0 0",
               got.err, got.rdata0, got.n_r, got.n_cs_ram);
    end
    n_cmp++;
    if (!idle_ok) begin n_bad++; $display("FAIL unmapped_ready_width: got extra cycle want one"); end
  endtask

  task automatic test_illegal();
    xfer_t got, exp;
    logic  idle_ok;
    bus_rdata = 16'h7777;
    set_m0(1'b1, 1'b1, 1'b1, 16'h0004, 16'h5A5A);
    do_round(got, exp, idle_ok);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL illegal_rw: got %h want %h", got, exp); end
    n_cmp++;
    if (got.n_w !== 4'd1 || got.n_r !== 4'd0 || got.err !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_rw_fixed: got w=%0d r=%0d err=%b want 1 0 1", got.n_w, got.n_r, got.err);
    end
    m0_r = 1'b0; m0_w = 1'b0;
  endtask

  task automatic test_contention();
    xfer_t got, exp;
    logic  idle_ok;
    int    wins[2];
    wins = '{0, 0};
    for (int i = 0; i < 16; i++) begin
      bus_rdata = 16'($urandom);
      if (!m0_req) set_m0(1'b1, 1'b1, 1'b0, rand_addr(0), 16'($urandom));
      if (!m1_req) set_m1(1'b1, 1'b1, 1'b0, rand_addr(0), 16'($urandom));
      do_round(got, exp, idle_ok);
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL contention[%0d]: got %h want %h", i, got, exp); end
      n_cmp++;
      if (!idle_ok) begin n_bad++; $display("FAIL contention_idle[%0d]: got busy want idle", i); end
      wins[got.winner]++;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (wins[0] < MAX_BURST || wins[1] < MAX_BURST) begin
      n_bad++;
      $display("FAIL contention_starve: got m0=%0d m1=%0d want each >= %0d", wins[0], wins[1], MAX_BURST);
    end
  endtask

  task automatic test_reset_mid_access();
    xfer_t got, exp;
    logic  idle_ok, quiet;
    set_m1(1'b1, 1'b0, 1'b1, 16'h9000, 16'hC0DE);
    @(negedge clk);
    n_cmp++;
    if ({bus_w, cs_diodes, m1_gnt} !== 3'b111) begin
      n_bad++;
      $display("FAIL mid_access_active: got %b want 111", {bus_w, cs_diodes, m1_gnt});
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus_w, cs_diodes, m1_gnt, m0_gnt, bus_addr} !== 20'h0) begin
      n_bad++;
      $display("FAIL mid_access_abort: got %h want 0", {bus_w, cs_diodes, m1_gnt, m0_gnt, bus_addr});
    end
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (m0_ready || m1_ready || m0_gnt || m1_gnt) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin n_bad++; $display("FAIL mid_access_no_ready: got activity want none"); end
    m1_req = 1'b0; m1_w = 1'b0;
    reset  = 1'b1;
    hist.delete();
    mdl_rdata = '{16'h0, 16'h0};
    @(negedge clk);
    bus_rdata = 16'h4321;
    set_m1(1'b1, 1'b1, 1'b0, 16'h9002, 16'h0000);
    do_round(got, exp, idle_ok);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL after_reset_xfer: got %h want %h", got, exp); end
    n_cmp++;
    if (!idle_ok) begin n_bad++; $display("FAIL after_reset_idle: got busy want idle"); end
    m1_r = 1'b0;
  endtask

  task automatic test_random();
    xfer_t got, exp;
    logic  idle_ok;
    int    kind, dir;
    for (int i = 0; i < 40; i++) begin
      bus_rdata = 16'($urandom);
      for (int m = 0; m < 2; m++) begin
        logic is_pend;
        is_pend = (m == 0) ? m0_req : m1_req;
        if (!is_pend && ($urandom_range(0, 1) == 1 || (!m0_req && !m1_req && m == 1))) begin
          kind = $urandom_range(0, 2);
          dir  = $urandom_range(0, 6);          // 0..2 read, 3..5 write, 6 both
          if (m == 0) set_m0(1'b1, dir < 3 || dir == 6, dir >= 3, rand_addr(kind), 16'($urandom));
          else        set_m1(1'b1, dir < 3 || dir == 6, dir >= 3, rand_addr(kind), 16'($urandom));
        end
      end
      do_round(got, exp, idle_ok);
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL random[%0d]: got %h want %h", i, got, exp); end
      n_cmp++;
      if (!idle_ok) begin n_bad++; $display("FAIL random_idle[%0d]: got busy want idle", i); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  initial begin
    set_m0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    bus_rdata = 16'h0;
    mdl_rdata = '{16'h0, 16'h0};
    test_reset();
    test_ram_read();
    test_io_write();
    test_no_direction();
    test_unmapped();
    test_illegal();
    test_contention();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
